// File: rtl/spm_mem_arbiter_pkg.sv
// spm_mem_arbiter_pkg: FSM states, port ids and default latency shared by the arbiter files
package spm_mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;
  localparam int DEF_MEM_LAT = 1;
endpackage

// File: rtl/spm_mem_arbiter_rr_arb2.sv
// spm_mem_arbiter_rr_arb2: two-way round-robin pick, the port not granted last wins a tie
module spm_mem_arbiter_rr_arb2
  import spm_mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       win_o
);
  assign win_o = &req_i ? ~last_i : (req_i[PORT_LDR] ? PORT_LDR : PORT_CPU);
endmodule

// File: rtl/spm_mem_arbiter.sv
// spm_mem_arbiter: shares one single-port memory between the CPU bus and the loader via req/ack
module spm_mem_arbiter
  import spm_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        gnt_o,
  output logic              busy_o,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e              state_q, state_d;
  logic                port_q, we_q, last_q, win;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [2:0]          cnt_q;
  logic [1:0]          owner;

  spm_mem_arbiter_rr_arb2 u_arb (
    .req_i  (req_i),
    .last_i (last_q),
    .win_o  (win)
  );

  always_comb
    state_d = state_q == IDLE   ? (|req_i ? ACCESS : IDLE) :
              state_q == ACCESS ? (we_q ? DONE : WAIT) :
              state_q == WAIT   ? (cnt_q == 3'd0 ? DONE : WAIT) : IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      port_q  <= PORT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 3'd0;
      last_q  <= PORT_LDR;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |req_i) begin
        port_q  <= win;
        we_q    <= we_i[win];
        addr_q  <= win ? addr1_i : addr0_i;
        wdata_q <= win ? wdata1_i : wdata0_i;
      end
      // cnt counts the remaining read-latency cycles spent in WAIT
      if (state_q == ACCESS) cnt_q <= 3'(MEM_LAT - 1);
      else if (state_q == WAIT) cnt_q <= cnt_q - 3'd1;
      if (state_q == WAIT && cnt_q == 3'd0) rdata_q <= mem_rdata;
      if (state_q == DONE) last_q <= port_q;
    end
  end

  assign owner     = port_q == PORT_LDR ? 2'b10 : 2'b01;
  assign gnt_o     = state_q != IDLE ? owner : 2'b00;
  assign ack_o     = state_q == DONE ? owner : 2'b00;
  assign busy_o    = state_q != IDLE;
  assign mem_en    = state_q == ACCESS;
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata_o   = rdata_q;
endmodule

// File: tb/tb_spm_mem_arbiter.sv
// tb_spm_mem_arbiter: directed scenarios plus random traffic against a transaction-level memory model
module tb_spm_mem_arbiter;
  localparam int LAT = 3;
  localparam int N_RAND = 10000;
  localparam int BOUND = 80000;
  logic clk = 1'b0, rst = 1'b1, init_mem = 1'b1;
  logic [1:0] req_i = '0, we_i = '0;
  logic [7:0] addr0_i = '0, addr1_i = '0, wdata0_i = '0, wdata1_i = '0;
  logic [1:0] ack_o, gnt_o;
  logic [7:0] rdata_o, mem_addr, mem_wdata, mem_rdata;
  logic busy_o, mem_en, mem_we;
  int errors = 0, checks = 0;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] pd [LAT];
  logic pv [LAT];

  always #5 clk = ~clk;

  spm_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .ack_o(ack_o), .rdata_o(rdata_o), .gnt_o(gnt_o), .busy_o(busy_o),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] init_val(int i);
    return 8'(i * 37 + 11);
  endfunction

  // memory macro: data is valid exactly LAT cycles after the strobe, inverted garbage otherwise
  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    pd[0] <= mem[mem_addr];
    pv[0] <= mem_en && !mem_we && !init_mem;
    for (int i = 1; i < LAT; i++) begin
      pd[i] <= pd[i-1];
      pv[i] <= pv[i-1];
    end
  end
  assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : ~pd[LAT-1];

  task automatic test_reset();
    rst = 1'b1; init_mem = 1'b1; req_i = '0; we_i = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    repeat (3) @(negedge clk);
    checks++;
    if ({ack_o, gnt_o, busy_o, mem_en, mem_we, mem_addr, mem_wdata, rdata_o} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b gnt=%b busy=%b en=%b we=%b addr=%h wd=%h rd=%h expected all zero", ack_o, gnt_o, busy_o, mem_en, mem_we, mem_addr, mem_wdata, rdata_o);
    end
    rst = 1'b0; init_mem = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({ack_o, gnt_o, busy_o, mem_en, mem_we, rdata_o} !== 14'd0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d got ack=%b gnt=%b busy=%b en=%b we=%b rd=%h expected all zero", c, ack_o, gnt_o, busy_o, mem_en, mem_we, rdata_o);
      end
    end
  endtask

  task automatic test_write_p0();
    req_i = 2'b01; we_i = 2'b01; addr0_i = 8'h10; wdata0_i = 8'hA5;
    ref_mem[8'h10] = 8'hA5;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, ack_o, gnt_o} !== {1'b1, 1'b1, 8'h10, 8'hA5, 2'b00, 2'b01}) begin
      errors++;
      $display("FAIL write_access got en=%b we=%b addr=%h wd=%h ack=%b gnt=%b expected 1 1 10 a5 00 01", mem_en, mem_we, mem_addr, mem_wdata, ack_o, gnt_o);
    end
    @(negedge clk);
    checks++;
    if ({ack_o, mem_en, mem_we} !== {2'b01, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL write_ack got ack=%b en=%b we=%b expected 01 0 0", ack_o, mem_en, mem_we);
    end
    req_i = '0; we_i = '0;
    @(negedge clk);
    checks++;
    if ({busy_o, ack_o, gnt_o} !== 5'd0) begin
      errors++;
      $display("FAIL write_idle got busy=%b ack=%b gnt=%b expected 0 00 00", busy_o, ack_o, gnt_o);
    end
  endtask

  task automatic test_read_p1();
    int n_en;
    n_en = 0;
    req_i = 2'b10; we_i = 2'b00; addr1_i = 8'h10;
    for (int c = 1; c <= 2 + LAT; c++) begin
      @(negedge clk);
      n_en += int'(mem_en);
      if (c < 2 + LAT) begin
        checks++;
        if (ack_o !== 2'b00) begin
          errors++;
          $display("FAIL read_early_ack cycle %0d got ack=%b expected 00", c, ack_o);
        end
      end
    end
    checks++;
    if ({ack_o, rdata_o} !== {2'b10, ref_mem[8'h10]} || n_en != 1) begin
      errors++;
      $display("FAIL read_p1 got ack=%b rdata=%h strobes=%0d expected 10 %h 1", ack_o, rdata_o, n_en, ref_mem[8'h10]);
    end
    req_i = '0;
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    req_i = 2'b01; we_i = 2'b00; addr0_i = 8'h20;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_access got en=%b expected 1", mem_en);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_o, ack_o, gnt_o, mem_en, rdata_o} !== 14'd0) begin
      errors++;
      $display("FAIL rst_mid_abort got busy=%b ack=%b gnt=%b en=%b rd=%h expected all zero", busy_o, ack_o, gnt_o, mem_en, rdata_o);
    end
    rst = 1'b0; req_i = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (ack_o !== 2'b00) begin
        errors++;
        $display("FAIL rst_mid_no_ack cycle %0d got ack=%b expected 00", c, ack_o);
      end
    end
  endtask

  task automatic test_alternate();
    int acks, ens, cyc;
    logic [1:0] exp;
    acks = 0; ens = 0; cyc = 0;
    req_i = 2'b11; we_i = 2'b11; addr0_i = 8'h30; wdata0_i = 8'h11; addr1_i = 8'h31; wdata1_i = 8'h22;
    ref_mem[8'h30] = 8'h11; ref_mem[8'h31] = 8'h22;
    while (acks < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mem_en) begin
        exp = ens % 2 == 0 ? 2'b01 : 2'b10;
        checks++;
        if ({gnt_o, mem_addr} !== {exp, exp == 2'b01 ? 8'h30 : 8'h31}) begin
          errors++;
          $display("FAIL alt_grant txn %0d got gnt=%b addr=%h expected %b", ens, gnt_o, mem_addr, exp);
        end
        ens++;
      end
      if (ack_o !== 2'b00) begin
        exp = acks % 2 == 0 ? 2'b01 : 2'b10;
        checks++;
        if (ack_o !== exp || acks + 1 != ens) begin
          errors++;
          $display("FAIL alt_ack txn %0d got ack=%b strobes=%0d expected %b %0d", acks, ack_o, ens, exp, acks + 1);
        end
        acks++;
      end
    end
    req_i = '0;
    checks++;
    if (acks != 8 || ens != 8) begin
      errors++;
      $display("FAIL alt_count got acks=%0d strobes=%0d expected 8 8", acks, ens);
    end
    @(negedge clk);
  endtask

  task automatic test_addr_change();
    req_i = 2'b01; we_i = 2'b00; addr0_i = 8'h31;
    @(negedge clk);
    addr0_i = 8'h30;
    for (int c = 2; c < 2 + LAT; c++) begin
      @(negedge clk);
      checks++;
      if (mem_addr !== 8'h31) begin
        errors++;
        $display("FAIL addr_hold cycle %0d got addr=%h expected 31", c, mem_addr);
      end
    end
    @(negedge clk);
    checks++;
    if ({ack_o, rdata_o} !== {2'b01, ref_mem[8'h31]}) begin
      errors++;
      $display("FAIL addr_change_data got ack=%b rdata=%h expected 01 %h", ack_o, rdata_o, ref_mem[8'h31]);
    end
    req_i = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit pend [2];
    bit p_we [2];
    logic [7:0] p_addr [2], p_wd [2];
    bit have, last, g_port, g_we, acked [2];
    logic [7:0] g_addr, g_wd, g_rd;
    int cyc, g_start, g_ack, done, acks, ens;
    logic [1:0] e_ack, e_gnt, oh;
    bit e_en;
    pend = '{0, 0}; have = 0; last = 1; cyc = 0; done = 0; acks = 0; ens = 0;
    g_start = 0; g_ack = 0; g_port = 0; g_we = 0; g_addr = '0; g_wd = '0; g_rd = '0;
    rst = 1'b1; req_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    while (done < N_RAND && cyc < BOUND) begin
      oh = g_port ? 2'b10 : 2'b01;
      e_ack = have && cyc == g_ack ? oh : 2'b00;
      e_gnt = have && cyc > g_start && cyc <= g_ack ? oh : 2'b00;
      e_en = have && cyc == g_start + 1;
      checks++;
      if ({ack_o, gnt_o, mem_en, mem_we} !== {e_ack, e_gnt, e_en, e_en & g_we}) begin
        errors++;
        $display("FAIL rand_ctrl cycle %0d got ack=%b gnt=%b en=%b we=%b expected %b %b %b %b", cyc, ack_o, gnt_o, mem_en, mem_we, e_ack, e_gnt, e_en, e_en & g_we);
      end
      if (e_en) begin
        checks++;
        if (mem_addr !== g_addr || (g_we && mem_wdata !== g_wd)) begin
          errors++;
          $display("FAIL rand_mem cycle %0d got addr=%h wd=%h expected %h %h", cyc, mem_addr, mem_wdata, g_addr, g_wd);
        end
      end
      if (e_ack != 2'b00 && !g_we) begin
        checks++;
        if (rdata_o !== g_rd) begin
          errors++;
          $display("FAIL rand_rdata cycle %0d addr=%h got %h expected %h", cyc, g_addr, rdata_o, g_rd);
        end
      end
      if (ack_o != 2'b00) acks++;
      if (mem_en) ens++;
      acked = '{0, 0};
      if (e_ack != 2'b00) begin
        pend[g_port] = 0;
        acked[g_port] = 1;
        done++;
      end
      for (int p = 0; p < 2; p++)
        if (!pend[p] && !acked[p] && $urandom_range(0, 3) != 0) begin
          pend[p] = 1;
          p_we[p] = 1'($urandom_range(0, 1));
          p_addr[p] = 8'($urandom_range(0, 15));
          p_wd[p] = 8'($urandom);
        end
      req_i = {pend[1], pend[0]};
      we_i = {p_we[1], p_we[0]};
      addr0_i = p_addr[0]; addr1_i = p_addr[1];
      wdata0_i = p_wd[0]; wdata1_i = p_wd[1];
      if ((!have || cyc > g_ack) && (pend[0] || pend[1])) begin
        g_port = pend[0] && pend[1] ? !last : pend[1];
        last = g_port;
        g_we = p_we[g_port]; g_addr = p_addr[g_port]; g_wd = p_wd[g_port];
        g_start = cyc;
        g_ack = cyc + (g_we ? 2 : 2 + LAT);
        have = 1;
        if (g_we) ref_mem[g_addr] = g_wd;
        else g_rd = ref_mem[g_addr];
      end else if (have && cyc > g_start && cyc < g_ack && $urandom_range(0, 1) == 1) begin
        // scramble the in-flight port's fields; the latched request must be unaffected
        if (g_port) begin addr1_i = 8'($urandom); wdata1_i = 8'($urandom); end
        else begin addr0_i = 8'($urandom); wdata0_i = 8'($urandom); end
        we_i[g_port] = 1'($urandom_range(0, 1));
      end
      cyc++;
      @(negedge clk);
    end
    req_i = '0;
    checks++;
    if (done != N_RAND || acks != ens || acks != done) begin
      errors++;
      $display("FAIL rand_totals got done=%0d acks=%0d strobes=%0d expected %0d each", done, acks, ens, N_RAND);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_p0();
    test_read_p1();
    test_rst_mid();
    test_alternate();
    test_addr_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
